// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the packet-locked AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLock
  } arb_state_e;

  localparam int unsigned DefNumStreams    = 2;
  localparam int unsigned DefTimeoutCycles = 256;

  // Width of a binary stream index; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, with wrap-around.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned N = DefNumStreams,
  parameter int unsigned W = sel_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W:0]   sum;
  logic [W-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (W+1)'(i);
      if (sum >= (W+1)'(N)) begin
        sum = sum - (W+1)'(N);
      end
      cand = sum[W-1:0];
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_stream_arbiter.sv
// Round-robin, packet-locked AXI-Stream arbiter driving an external stream mux select.
// Optional stall watchdog compiled in with `define AXIS_ARB_TIMEOUT_EN.
module axi_stream_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_STREAMS    = DefNumStreams,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_STREAMS-1:0] s_tvalid,
  input  logic [NUM_STREAMS-1:0] s_tlast,
  output logic [NUM_STREAMS-1:0] s_tready,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [NUM_STREAMS-1:0] select,
  output logic                   grant_active,
  output logic                   timeout
);

  localparam int unsigned SelW = sel_width(NUM_STREAMS);

  if (NUM_STREAMS < 2 || NUM_STREAMS > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("axi_stream_arbiter: parameter out of range");
  end

  arb_state_e      state_q, state_d;
  logic [SelW-1:0] grant_q, grant_d;
  logic [SelW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SelW-1:0] next_ptr;
  logic [SelW-1:0] pick_idx;
  logic            pick_found;
  logic            gnt_valid;
  logic            gnt_last;
  logic            xfer;
  logic            stall_revoke;

  rr_pick #(
    .N(NUM_STREAMS),
    .W(SelW)
  ) u_rr_pick (
    .req_i  (s_tvalid),
    .ptr_i  (rr_ptr_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  assign gnt_valid    = s_tvalid[grant_q];
  assign gnt_last     = s_tlast[grant_q];
  assign xfer         = (state_q == StLock) && gnt_valid && m_tready;
  assign next_ptr     = (grant_q == SelW'(NUM_STREAMS - 1)) ? '0 : grant_q + 1'b1;
  assign grant_active = (state_q == StLock);
  assign select       = NUM_STREAMS'(grant_q);

  // Valid/ready are routed combinationally so a locked packet streams at full rate.
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    if (state_q == StLock) begin
      m_tvalid          = gnt_valid;
      s_tready[grant_q] = m_tready;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = StLock;
        end
      end
      StLock: begin
        if ((xfer && gnt_last) || stall_revoke) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef AXIS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic            timeout_q;

  // Revoke on the edge that completes the TIMEOUT_CYCLES-th consecutive stalled cycle.
  always_comb begin
    stall_cnt_d  = '0;
    stall_revoke = 1'b0;
    if (state_q == StLock && !gnt_valid) begin
      if (stall_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        stall_revoke = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= stall_revoke;
    end
  end

  assign timeout = timeout_q;
`else
  assign stall_revoke = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: doc/axi_stream_arbiter.md
# axi_stream_arbiter

Round-robin, packet-locked arbiter that shares one AXI-Stream output between NUM_STREAMS input streams. It sits beside the stream multiplexer, drives that multiplexer's `select` port, and routes TVALID/TREADY between the granted input and the output. Grants are held from the first beat of a packet until its TLAST handshake, so packets from different sources never interleave.

## Interface
- `NUM_STREAMS`, default 2: number of requesting input streams, 2..16.
- `TIMEOUT_CYCLES`, default 256: stall limit for the watchdog; used only when `AXIS_ARB_TIMEOUT_EN` is defined; ≥ 2.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `s_tvalid` in NUM_STREAMS: per-input TVALID.
- `s_tlast` in NUM_STREAMS: per-input TLAST.
- `s_tready` out NUM_STREAMS: per-input TREADY.
- `m_tvalid` out 1: output TVALID.
- `m_tready` in 1: output TREADY.
- `select` out NUM_STREAMS: binary index of the granted input, zero-extended; connects directly to the mux `select`.
- `grant_active` out 1: high while a packet is locked.
- `timeout` out 1: one-cycle pulse when the watchdog revokes a grant; tied 0 when the watchdog is compiled out.

## Operation
- FSM states:
  - IDLE: no grant.
  - LOCK: one input granted.
- In IDLE:
  - `m_tvalid`=0 and all `s_tready`=0.
  - If any `s_tvalid` is set, pick the first requester at or after `rr_ptr`, in increasing index with wrap-around.
  - Register the pick as `grant`, set `select`=`grant`, and go to LOCK.
- In LOCK:
  - `m_tvalid` = `s_tvalid[grant]`.
  - `s_tready[grant]` = `m_tready`; all other `s_tready` = 0. Both paths are combinational.
- A beat transfers when `m_tvalid & m_tready`.
- On a transfer with `s_tlast[grant]`=1:
  - Go to IDLE.
  - Set `rr_ptr` = (`grant`+1) mod NUM_STREAMS.
- A granted source that drops TVALID mid-packet keeps the grant. There is no preemption.
- A requester that deasserts TVALID while in IDLE before being picked is simply not picked. This is legal only between packets.
- `select` holds its last value in IDLE. It changes only on the IDLE→LOCK edge.
- Single-beat packets (TLAST on the first beat) are legal.
- Reset values:
  - state = IDLE, `rr_ptr` = 0, `grant` = 0, `select` = 0.
  - `grant_active` = 0, `timeout` = 0, `m_tvalid` = 0, `s_tready` = 0.
- Reset mid-packet:
  - Takes effect on the next edge with `rst_n` low. The packet is abandoned and no further beats are accepted.
  - After `rst_n` rises, arbitration restarts from index 0.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N gives `s_tready`/`m_tvalid` live from cycle N+1.
- Per packet: 1 idle cycle between a TLAST handshake and the next grant. Sustained throughput is L/(L+1) for L-beat packets.
- Within a packet, with TVALID and TREADY both held high: 1 beat per cycle, zero added latency.
- `grant_active` is registered. It equals (state == LOCK).
- Fairness: with all inputs continuously requesting, grants rotate 0,1,…,N−1,0, …

## Configuration
- Macro: `AXIS_ARB_TIMEOUT_EN`.
- When defined:
  - A counter increments each LOCK cycle where `s_tvalid[grant]`=0. It clears on any cycle with `s_tvalid[grant]`=1 and on leaving LOCK.
  - When the count reaches TIMEOUT_CYCLES, the FSM returns to IDLE, `rr_ptr` advances past `grant`, and `timeout` pulses for 1 cycle.
  - The rest of the abandoned packet arrives later as a new packet. Handling it is a downstream concern.
- When undefined:
  - No counter is built and `timeout` is constant 0.
  - A stalled source holds the output indefinitely.

## Structure
- Package `axis_arb_pkg` holds:
  - the state enum (IDLE, LOCK);
  - function `sel_width(n)` = max(1, clog2(n));
  - default constants for NUM_STREAMS and TIMEOUT_CYCLES.
- Sub-module `rr_pick`: a combinational round-robin priority picker.
  - Inputs: request vector and pointer.
  - Outputs: `found` and the index.
  - Instantiated once.
- The data/TLAST muxing stays in the existing stream mux. This block carries no data bits.

## Test plan
- Single requester: `s_tvalid`=01, 3-beat packet with TLAST on beat 3, `m_tready`=1 → `select`=0, `s_tready`=01 from the cycle after the request, 3 transfers, IDLE for 1 cycle, `rr_ptr`=1.
- Both requesting continuously, 2-beat packets → grant order 0,1,0,1, with no interleaved beats and `select` changing only between packets.
- Backpressure: `m_tready` toggles 1,0,1,0 during a 4-beat packet from input 1 → `s_tready[1]` mirrors `m_tready`, `s_tready[0]`=0 throughout, 4 transfers total.
- Source stall: input 0 drops TVALID for 10 cycles mid-packet while input 1 requests → grant stays 0 (macro undefined). With the macro defined and TIMEOUT_CYCLES=4 → `timeout` pulse after 4 stalled cycles, then grant 1.
- Reset mid-packet: `rst_n`=0 on beat 2 of 5 → next cycle all outputs are at reset values. After release, with both requesting → grant 0.
